// File: rtl/timer_pkg.sv
// Shared definitions for the seconds-timer run-control sequencer and the timer it drives.
package timer_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    PAUSE = 3'd2,
    DONE  = 3'd3,
    CLEAR = 3'd4
  } state_t;

  // Modulo select codes understood by the timer.
  localparam logic MOD_SHORT = 1'b0;
  localparam logic MOD_LONG  = 1'b1;

  // Bits needed for a counter running 0..n-1 (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/timer_seq_ctrl_if.sv
// Control/status link between the run sequencer (master) and the BCD timer (slave).
interface timer_seq_ctrl_if;
  logic timer_en;
  logic timer_clr_N;
  logic modulo_sel;
  logic wrap_in;

  modport master (output timer_en, output timer_clr_N, output modulo_sel, input wrap_in);
  modport slave  (input timer_en, input timer_clr_N, input modulo_sel, output wrap_in);
endinterface

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stability counter, one-cycle press pulse.
module btn_debounce
  import timer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_N,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press
);
  localparam int unsigned       CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync;
  logic [CNT_W-1:0] cnt;
  logic             level_d;

  always_ff @(posedge clk or negedge rst_N) begin
    if (!rst_N) begin
      sync      <= '0;
      cnt       <= '0;
      btn_level <= 1'b0;
      level_d   <= 1'b0;
      btn_press <= 1'b0;
    end else begin
      sync      <= {sync[0], btn_raw};
      level_d   <= btn_level;
      btn_press <= btn_level & ~level_d;
      // Any sample matching the accepted level restarts the stability count.
      if (sync[1] == btn_level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt       <= '0;
        btn_level <= sync[1];
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/timer_seq_ctrl.sv
// Run-control sequencer for the BCD seconds timer: debounced buttons, IDLE/RUN/PAUSE/DONE
// control, count-enable prescaler, modulo latch and wrap counting up to a limit.
module timer_seq_ctrl
  import timer_pkg::*;
#(
  parameter int unsigned CLK_HZ          = 50_000_000,
  parameter int unsigned TICK_HZ         = 1,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter logic [7:0]  WRAP_LIMIT      = 8'd10
) (
  input  logic             clk,
  input  logic             rst_N,
  input  logic             start_btn,
  input  logic             clear_btn,
  input  logic             mode_SW,
  timer_seq_ctrl_if.master tmr,
  output logic             run_LED,
  output logic             done_LED,
  output logic [7:0]       wrap_cnt
);
  localparam int unsigned      TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned      PRE_W    = cnt_width(TICK_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  logic             start_press;
  logic             clear_press;
  logic [1:0]       btn_level_unused;

  state_t           state, state_nx;
  logic [PRE_W-1:0] presc, presc_nx;
  logic [7:0]       wrap_cnt_nx;
  logic             en_nx;
  logic             terminal;
  logic             wrap_seen;
  logic             limit_hit;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start_db (
    .clk       (clk),
    .rst_N     (rst_N),
    .btn_raw   (start_btn),
    .btn_level (btn_level_unused[0]),
    .btn_press (start_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear_db (
    .clk       (clk),
    .rst_N     (rst_N),
    .btn_raw   (clear_btn),
    .btn_level (btn_level_unused[1]),
    .btn_press (clear_press)
  );

  assign terminal  = (presc == PRE_LAST);
  assign wrap_seen = (state == RUN) && tmr.wrap_in;
  assign limit_hit = wrap_seen && ((wrap_cnt + 8'd1) == WRAP_LIMIT);

  always_comb begin
    state_nx    = state;
    presc_nx    = presc;
    wrap_cnt_nx = wrap_cnt;
    en_nx       = 1'b0;
    unique case (state)
      IDLE: begin
        presc_nx = '0;
        if (start_press) state_nx = RUN;
      end
      RUN: begin
        presc_nx = terminal ? '0 : presc + PRE_W'(1);
        // The wrap that reaches the limit also swallows a coincident terminal count.
        en_nx    = terminal && !limit_hit;
        if (wrap_seen && (wrap_cnt < WRAP_LIMIT)) wrap_cnt_nx = wrap_cnt + 8'd1;
        if (limit_hit)        state_nx = DONE;
        else if (start_press) state_nx = PAUSE;
      end
      PAUSE: begin
        if (start_press) state_nx = RUN;
      end
      DONE: begin
        state_nx = DONE;
      end
      CLEAR: begin
        state_nx    = IDLE;
        presc_nx    = '0;
        wrap_cnt_nx = '0;
      end
      default: state_nx = IDLE;
    endcase
    if (clear_press) begin
      state_nx    = CLEAR;
      presc_nx    = '0;
      wrap_cnt_nx = '0;
      en_nx       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_N) begin
    if (!rst_N) begin
      state           <= IDLE;
      presc           <= '0;
      wrap_cnt        <= '0;
      tmr.timer_en    <= 1'b0;
      tmr.timer_clr_N <= 1'b1;
      tmr.modulo_sel  <= MOD_SHORT;
      run_LED         <= 1'b0;
      done_LED        <= 1'b0;
    end else begin
      state           <= state_nx;
      presc           <= presc_nx;
      wrap_cnt        <= wrap_cnt_nx;
      tmr.timer_en    <= en_nx;
      tmr.timer_clr_N <= (state_nx != CLEAR);
      run_LED         <= (state_nx == RUN);
      done_LED        <= (state_nx == DONE);
      if (state == IDLE) tmr.modulo_sel <= mode_SW ? MOD_LONG : MOD_SHORT;
    end
  end

endmodule

// File: tb/tb_timer_seq_ctrl.sv
// Bench for timer_seq_ctrl: directed scenarios plus a random tail, every cycle compared
// against a behavioural model built from the run-control rules.
module tb_timer_seq_ctrl;
  localparam int TICK_DIV = 10;
  localparam int DB       = 4;
  localparam int LIMIT    = 3;

  logic       clk = 1'b0;
  logic       rst_N;
  logic       start_btn;
  logic       clear_btn;
  logic       mode_SW;
  logic       run_LED;
  logic       done_LED;
  logic [7:0] wrap_cnt;

  timer_seq_ctrl_if tmr();

  timer_seq_ctrl #(
    .CLK_HZ          (20),
    .TICK_HZ         (2),
    .DEBOUNCE_CYCLES (DB),
    .WRAP_LIMIT      (8'(LIMIT))
  ) dut (
    .clk       (clk),
    .rst_N     (rst_N),
    .start_btn (start_btn),
    .clear_btn (clear_btn),
    .mode_SW   (mode_SW),
    .tmr       (tmr),
    .run_LED   (run_LED),
    .done_LED  (done_LED),
    .wrap_cnt  (wrap_cnt)
  );

  always #5 clk = ~clk;

  typedef enum {M_IDLE, M_RUN, M_PAUSE, M_DONE, M_CLEAR} mstate_t;
  mstate_t     ms;
  int          phase;
  int          wraps;
  bit [DB+1:0] hist_s, hist_c;
  bit          lvl_s, lvl_c, rose_s, rose_c, prs_s, prs_c;
  bit          exp_en, exp_clrn, exp_mod, exp_run, exp_done;
  int          vectors, errors, en_seen, clr_low;

  task automatic cmp(input string tag, input logic [7:0] got, input logic [7:0] want);
    vectors++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic model_reset();
    ms = M_IDLE; phase = 0; wraps = 0;
    hist_s = '0; hist_c = '0;
    lvl_s = 0; lvl_c = 0; rose_s = 0; rose_c = 0; prs_s = 0; prs_c = 0;
    exp_en = 0; exp_clrn = 1; exp_mod = 0; exp_run = 0; exp_done = 0;
  endtask

  // A button level is accepted once DB consecutive synchronized samples (two cycles old)
  // all disagree with it; the press shows one cycle after the accepted rise.
  task automatic db_step(input bit raw, inout bit [DB+1:0] hist, inout bit lvl,
                         inout bit rose, inout bit prs);
    prs  = rose;
    rose = 1'b0;
    hist = {hist[DB:0], raw};
    if (hist[DB+1:2] == {DB{~lvl}}) begin
      lvl  = ~lvl;
      rose = lvl;
    end
  endtask

  task automatic model_step();
    bit      sp, cp, last, nxt_en;
    mstate_t ns;
    sp = prs_s; cp = prs_c; last = 0; nxt_en = 0; ns = ms;
    if (ms == M_IDLE) exp_mod = mode_SW;
    case (ms)
      M_IDLE: begin
        phase = 0;
        if (sp) ns = M_RUN;
      end
      M_RUN: begin
        last   = (tmr.wrap_in === 1'b1) && (wraps + 1 == LIMIT);
        nxt_en = (phase == TICK_DIV - 1) && !last;
        phase  = (phase + 1) % TICK_DIV;
        if ((tmr.wrap_in === 1'b1) && wraps < LIMIT) wraps++;
        if (last)    ns = M_DONE;
        else if (sp) ns = M_PAUSE;
      end
      M_PAUSE: if (sp) ns = M_RUN;
      M_CLEAR: ns = M_IDLE;
      default: ;
    endcase
    if (cp) begin
      ns = M_CLEAR; phase = 0; wraps = 0; nxt_en = 0;
    end
    db_step(start_btn, hist_s, lvl_s, rose_s, prs_s);
    db_step(clear_btn, hist_c, lvl_c, rose_c, prs_c);
    exp_en   = nxt_en;
    exp_clrn = (ns != M_CLEAR);
    exp_run  = (ns == M_RUN);
    exp_done = (ns == M_DONE);
    ms = ns;
  endtask

  task automatic check_outputs();
    cmp("timer_en",    8'(tmr.timer_en),    8'(exp_en));
    cmp("timer_clr_N", 8'(tmr.timer_clr_N), 8'(exp_clrn));
    cmp("modulo_sel",  8'(tmr.modulo_sel),  8'(exp_mod));
    cmp("run_LED",     8'(run_LED),         8'(exp_run));
    cmp("done_LED",    8'(done_LED),        8'(exp_done));
    cmp("wrap_cnt",    wrap_cnt,            8'(wraps));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_N) model_step();
    #1;
    check_outputs();
    if (tmr.timer_en === 1'b1)    en_seen++;
    if (tmr.timer_clr_N === 1'b0) clr_low++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int n;
    vectors = 0; errors = 0; en_seen = 0; clr_low = 0;
    rst_N = 0; start_btn = 0; clear_btn = 0; mode_SW = 0; tmr.wrap_in = 0;
    model_reset();
    ticks(3);
    rst_N = 1;
    ticks(5);

    // Short glitch on start must not be accepted.
    start_btn = 1; ticks(int'($urandom_range(1, 3))); start_btn = 0;
    ticks(12);
    cmp("glitch_no_run", 8'(run_LED), 8'd0);

    // Start press: press pulse after 7 cycles, RUN one cycle later, tick every 10.
    start_btn = 1; ticks(7);
    cmp("run_before_press", 8'(run_LED), 8'd0);
    tick();
    cmp("run_after_press", 8'(run_LED), 8'd1);
    ticks(2); start_btn = 0;
    en_seen = 0; ticks(40);
    cmp("tick_count_40", 8'(en_seen), 8'd4);

    // Pause with the prescaler at 6, hold, resume.
    n = 0;
    while (phase != 8 && n < 2 * TICK_DIV) begin tick(); n++; end
    vectors++;
    assert (n < 2 * TICK_DIV) else begin
      errors++;
      $error("FAIL phase_wait: waited %0d cycles, limit %0d", n, 2 * TICK_DIV);
    end
    start_btn = 1; ticks(8);
    cmp("paused", 8'(run_LED), 8'd0);
    ticks(2); start_btn = 0;
    en_seen = 0; ticks(40);
    cmp("no_en_in_pause", 8'(en_seen), 8'd0);
    start_btn = 1; ticks(8);
    cmp("resumed", 8'(run_LED), 8'd1);
    en_seen = 0; ticks(3);
    cmp("no_en_yet", 8'(en_seen), 8'd0);
    tick();
    cmp("en_after_resume", 8'(tmr.timer_en), 8'd1);
    start_btn = 0; ticks(10);

    // Wraps up to the limit, then DONE ignores start, wraps and issues no ticks.
    for (int i = 0; i < LIMIT; i++) begin
      ticks(int'($urandom_range(2, 6)));
      tmr.wrap_in = 1; tick(); tmr.wrap_in = 0;
      cmp("wrap_cnt_step", wrap_cnt, 8'(i + 1));
    end
    cmp("done_led", 8'(done_LED), 8'd1);
    cmp("run_led_off", 8'(run_LED), 8'd0);
    en_seen = 0; ticks(30);
    cmp("no_en_in_done", 8'(en_seen), 8'd0);
    start_btn = 1; ticks(10); start_btn = 0; ticks(10);
    cmp("start_ignored_done", 8'(done_LED), 8'd1);
    tmr.wrap_in = 1; tick(); tmr.wrap_in = 0;
    cmp("wrap_ignored_done", wrap_cnt, 8'(LIMIT));

    // Clear back to IDLE; modulo follows the switch only there.
    clear_btn = 1; ticks(10); clear_btn = 0; ticks(10);
    cmp("cleared_cnt", wrap_cnt, 8'd0);
    cmp("idle_done_off", 8'(done_LED), 8'd0);
    mode_SW = 1; ticks(3);
    cmp("mod_follow_idle", 8'(tmr.modulo_sel), 8'd1);
    start_btn = 1; ticks(10); start_btn = 0;
    cmp("run_long_mod", 8'(run_LED), 8'd1);
    mode_SW = 0; ticks(20);
    cmp("mod_frozen_run", 8'(tmr.modulo_sel), 8'd1);
    tmr.wrap_in = 1; tick(); tmr.wrap_in = 0;
    cmp("wrap_one", wrap_cnt, 8'd1);
    ticks(5);

    // Clear, start and wrap all in the same cycle: clear wins.
    clr_low = 0;
    start_btn = 1; clear_btn = 1; ticks(7);
    cmp("clr_not_yet", 8'(clr_low), 8'd0);
    tmr.wrap_in = 1; tick(); tmr.wrap_in = 0;
    cmp("clr_pulse_low", 8'(tmr.timer_clr_N), 8'd0);
    cmp("clr_cnt_zero", wrap_cnt, 8'd0);
    ticks(2); start_btn = 0; clear_btn = 0; ticks(15);
    cmp("clr_one_cycle", 8'(clr_low), 8'd1);
    cmp("idle_after_clear", 8'(run_LED), 8'd0);
    cmp("mod_follows_again", 8'(tmr.modulo_sel), 8'd0);

    // Asynchronous reset in the middle of RUN.
    start_btn = 1; ticks(10); start_btn = 0; ticks(15);
    cmp("run_before_reset", 8'(run_LED), 8'd1);
    rst_N = 0; model_reset(); #1;
    check_outputs();
    ticks(3);
    rst_N = 1;
    en_seen = 0; ticks(30);
    cmp("no_en_after_reset", 8'(en_seen), 8'd0);
    cmp("idle_after_reset", 8'(run_LED), 8'd0);

    // Random tail: buttons with random hold/release, wraps and switch flips.
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 4))
        0: begin
          start_btn = 1; ticks(int'($urandom_range(1, 12)));
          start_btn = 0; ticks(int'($urandom_range(1, 12)));
        end
        1: begin
          clear_btn = 1; ticks(int'($urandom_range(1, 8)));
          clear_btn = 0; ticks(int'($urandom_range(1, 8)));
        end
        2: begin
          tmr.wrap_in = 1; tick(); tmr.wrap_in = 0;
          ticks(int'($urandom_range(0, 4)));
        end
        3: begin
          mode_SW = 1'($urandom_range(0, 1)); tick();
        end
        default: ticks(int'($urandom_range(1, 25)));
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
